// File: rtl/mold_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mold_pkg
//  Purpose : Shared types and default widths for the Mold message buffer.
//            Holds the admission FSM state enum, the FIFO entry layout and
//            the default parameter values used by mold_msg_buf.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package mold_pkg;

   localparam int MOLD_AXI_DATA_W = 64;
   localparam int MOLD_AXI_KEEP_W = MOLD_AXI_DATA_W / 8;
   localparam int MOLD_ML_W       = 16;
   localparam int MOLD_DEPTH      = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   // Entry layout at the default widths. The FIFO stores the same field
   // order {start, last, len, mask, data} as a flat vector so that the
   // top-level parameters can override the widths.
   typedef struct packed {
      logic                       start;
      logic                       last;
      logic [MOLD_ML_W-1:0]       len;
      logic [MOLD_AXI_KEEP_W-1:0] mask;
      logic [MOLD_AXI_DATA_W-1:0] data;
   } entry_t;

endpackage : mold_pkg
`default_nettype wire

// File: rtl/cnt_ones_thermo.sv
`default_nettype none
// ============================================================================
//  Module  : cnt_ones_thermo
//  Purpose : Number of set bits in a thermometer-coded mask (ones packed
//            from bit 0 upward). For such a code the count equals the index
//            of the highest set bit plus one.
//  Ports   : i_mask  - thermometer byte mask
//            o_cnt   - number of ones
//  Rev     : 1.0  initial release
// ============================================================================
module cnt_ones_thermo #(
   parameter int W = 8
) (
   input  logic [W-1:0]             i_mask,
   output logic [$clog2(W+1)-1:0]   o_cnt
);

   localparam int CW = $clog2(W + 1);

   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < W; i++) begin
         if (i_mask[i]) o_cnt = CW'(i + 1);
      end
   end

endmodule : cnt_ones_thermo
`default_nettype wire

// File: rtl/mold_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : mold_fifo
//  Purpose : First-word fall-through FIFO of DEPTH entries (power of 2).
//            Storage is not reset; pointers wrap naturally.
//  Ports   : clk, nreset          - clock, async active-low reset
//            i_push, i_wdata      - write strobe and entry
//            i_pop                - consume head entry
//            o_rdata              - head entry (valid while !o_empty)
//            o_occ, o_full, o_empty - occupancy and status
//  Rev     : 1.0  initial release
// ============================================================================
module mold_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic                     i_push,
   input  logic [W-1:0]             i_wdata,
   input  logic                     i_pop,
   output logic [W-1:0]             o_rdata,
   output logic [$clog2(DEPTH):0]   o_occ,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_occ;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_occ == (AW+1)'(DEPTH));
   assign o_empty = (r_occ == '0);
   assign o_occ   = r_occ;
   assign o_rdata = r_mem[r_rptr];

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop  & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + (AW+1)'(1);
            2'b01:   r_occ <= r_occ - (AW+1)'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule : mold_fifo
`default_nettype wire

// File: rtl/mold_msg_buf.sv
`default_nettype none
// ============================================================================
//  Module  : mold_msg_buf
//  Purpose : Admission-controlled message buffer. A message is admitted
//            whole at its start beat only if the FIFO has room for all its
//            beats; otherwise it is dropped and counted.
//  Ports   : clk, nreset                         - clock, async active-low reset
//            mold_msg_v_i/start_i/len_i/mask_i/data_i - input beats (no ready)
//            out_ready_i                         - consumer ready
//            out_v_o/start_o/last_o/len_o/mask_o/data_o - FWFT output beat
//            drop_cnt_o                          - saturating drop counter
//            len_err_o, overflow_o               - single-cycle error pulses
//  Rev     : 1.0  initial release
// ============================================================================
module mold_msg_buf
   import mold_pkg::*;
#(
   parameter int AXI_DATA_W = MOLD_AXI_DATA_W,
   parameter int AXI_KEEP_W = MOLD_AXI_KEEP_W,
   parameter int ML_W       = MOLD_ML_W,
   parameter int DEPTH      = MOLD_DEPTH
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  mold_msg_v_i,
   input  logic                  mold_msg_start_i,
   input  logic [ML_W-1:0]       mold_msg_len_i,
   input  logic [AXI_KEEP_W-1:0] mold_msg_mask_i,
   input  logic [AXI_DATA_W-1:0] mold_msg_data_i,
   input  logic                  out_ready_i,
   output logic                  out_v_o,
   output logic                  out_start_o,
   output logic                  out_last_o,
   output logic [ML_W-1:0]       out_len_o,
   output logic [AXI_KEEP_W-1:0] out_mask_o,
   output logic [AXI_DATA_W-1:0] out_data_o,
   output logic [15:0]           drop_cnt_o,
   output logic                  len_err_o,
   output logic                  overflow_o
);

   localparam int BPB     = AXI_DATA_W / 8;
   localparam int BPB_LG  = $clog2(BPB);
   localparam int AW      = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(AXI_KEEP_W + 1);
   localparam int ENTRY_W = 2 + ML_W + AXI_KEEP_W + AXI_DATA_W;

   state_t            r_state, w_state_nxt;
   logic [ML_W-1:0]   r_rem, w_rem_nxt;
   logic [ML_W-1:0]   r_len, w_len_nxt;
   logic [15:0]       r_drop_cnt;
   logic              r_len_err, w_len_err;
   logic              r_ovf, w_ovf;
   logic              w_drop_inc;
   logic              w_push, w_push_start, w_push_last;

   logic [CNT_W-1:0]  w_pc;
   logic [ML_W-1:0]   w_pc_ml;
   logic [ML_W:0]     w_need;
   logic [AW:0]       w_free;
   logic              w_fits;

   logic [AW:0]       w_occ;
   logic              w_full, w_empty;
   logic [ENTRY_W-1:0] w_wdata, w_rdata;

   cnt_ones_thermo #(.W(AXI_KEEP_W)) u_popcnt (
      .i_mask (mold_msg_mask_i),
      .o_cnt  (w_pc)
   );

   assign w_pc_ml = ML_W'(w_pc);

   // Beats needed by the whole message, against free slots from the
   // registered occupancy (a same-cycle pop is deliberately not credited).
   assign w_need = ({1'b0, mold_msg_len_i} + (ML_W+1)'(BPB - 1)) >> BPB_LG;
   assign w_free = (AW+1)'(DEPTH) - w_occ;
   assign w_fits = (w_need <= (ML_W+1)'(w_free));

   always_comb begin
      w_state_nxt  = r_state;
      w_rem_nxt    = r_rem;
      w_len_nxt    = r_len;
      w_push       = 1'b0;
      w_push_start = 1'b0;
      w_push_last  = 1'b0;
      w_len_err    = 1'b0;
      w_ovf        = 1'b0;
      w_drop_inc   = 1'b0;
      if (mold_msg_v_i) begin
         if (mold_msg_start_i) begin
            // A start while a message is open truncates it (no last beat).
            if (r_state == ST_PASS) w_len_err = 1'b1;
            if (mold_msg_len_i == '0) begin
               w_len_err   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (!w_fits) begin
               w_ovf       = 1'b1;
               w_drop_inc  = 1'b1;
               w_state_nxt = ST_DROP;
            end else begin
               w_push       = 1'b1;
               w_push_start = 1'b1;
               w_len_nxt    = mold_msg_len_i;
               if (w_pc_ml >= mold_msg_len_i) begin
                  w_rem_nxt   = '0;
                  w_push_last = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_rem_nxt   = mold_msg_len_i - w_pc_ml;
                  w_state_nxt = ST_PASS;
               end
            end
         end else begin
            case (r_state)
               ST_PASS: begin
                  w_push = ~w_full;
                  if (w_pc_ml > r_rem) begin
                     // Over-long beat: close the message here.
                     w_len_err   = 1'b1;
                     w_rem_nxt   = '0;
                     w_push_last = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_rem_nxt = r_rem - w_pc_ml;
                     if (r_rem == w_pc_ml) begin
                        w_push_last = 1'b1;
                        w_state_nxt = ST_IDLE;
                     end
                  end
               end
               ST_DROP: ;
               default: w_len_err = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state    <= ST_IDLE;
         r_rem      <= '0;
         r_len      <= '0;
         r_drop_cnt <= '0;
         r_len_err  <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rem     <= w_rem_nxt;
         r_len     <= w_len_nxt;
         r_len_err <= w_len_err;
         r_ovf     <= w_ovf;
         if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign w_wdata = {w_push_start, w_push_last, w_len_nxt, mold_msg_mask_i, mold_msg_data_i};

   mold_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .nreset  (nreset),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (out_v_o & out_ready_i),
      .o_rdata (w_rdata),
      .o_occ   (w_occ),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign out_v_o = ~w_empty;
   assign {out_start_o, out_last_o, out_len_o, out_mask_o, out_data_o} = w_rdata;
   assign drop_cnt_o = r_drop_cnt;
   assign len_err_o  = r_len_err;
   assign overflow_o = r_ovf;

endmodule : mold_msg_buf
`default_nettype wire

// File: tb/tb_mold_msg_buf.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mold_msg_buf
//  Purpose : Self-checking bench for mold_msg_buf with a message-level
//            reference model (queue of expected output beats).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mold_msg_buf;

   localparam int DEPTH = 8;
   localparam int BPB   = 8;

   logic        clk = 1'b0;
   logic        nreset;
   logic        in_v, in_start, in_rdy;
   logic [15:0] in_len;
   logic [7:0]  in_mask;
   logic [63:0] in_data;

   logic        out_v_o, out_start_o, out_last_o;
   logic [15:0] out_len_o;
   logic [7:0]  out_mask_o;
   logic [63:0] out_data_o;
   logic [15:0] drop_cnt_o;
   logic        len_err_o, overflow_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mold_msg_buf dut (
      .clk              (clk),
      .nreset           (nreset),
      .mold_msg_v_i     (in_v),
      .mold_msg_start_i (in_start),
      .mold_msg_len_i   (in_len),
      .mold_msg_mask_i  (in_mask),
      .mold_msg_data_i  (in_data),
      .out_ready_i      (in_rdy),
      .out_v_o          (out_v_o),
      .out_start_o      (out_start_o),
      .out_last_o       (out_last_o),
      .out_len_o        (out_len_o),
      .out_mask_o       (out_mask_o),
      .out_data_o       (out_data_o),
      .drop_cnt_o       (drop_cnt_o),
      .len_err_o        (len_err_o),
      .overflow_o       (overflow_o)
   );

   // ------------------------------------------------------------------
   // Reference model: message-level bookkeeping plus a queue of the
   // beats the consumer should see, in order.
   // ------------------------------------------------------------------
   typedef struct {
      bit          start;
      bit          last;
      int          len;
      logic [7:0]  mask;
      logic [63:0] data;
   } beat_t;

   beat_t q[$];
   bit    m_in_msg, m_dropping;
   int    m_rem, m_len, m_drop;
   bit    exp_lerr, exp_ovf;

   wire [89:0] dut_head = {out_start_o, out_last_o, out_len_o, out_mask_o, out_data_o};

   function automatic logic [89:0] exp_head();
      return {q[0].start, q[0].last, 16'(q[0].len), q[0].mask, q[0].data};
   endfunction

   function automatic logic [7:0] thermo(input int n);
      int v;
      v = (1 << n) - 1;
      return v[7:0];
   endfunction

   task automatic model_reset();
      q.delete();
      m_in_msg = 0; m_dropping = 0; m_rem = 0; m_len = 0; m_drop = 0;
      exp_lerr = 0; exp_ovf = 0;
   endtask

   // Evaluates the beat currently on the inputs against the message rules.
   task automatic model_step();
      bit    lerr, ovf, do_push;
      int    occ, pc, need;
      beat_t nb;
      lerr = 0; ovf = 0; do_push = 0;
      occ  = q.size();
      nb   = '{default: 0};
      if (in_v) begin
         pc = $countones(in_mask);
         if (in_start) begin
            if (m_in_msg) lerr = 1;
            m_in_msg = 0; m_dropping = 0;
            if (in_len == 0) begin
               lerr = 1;
            end else begin
               need = (int'(in_len) + BPB - 1) / BPB;
               if (need > DEPTH - occ) begin
                  m_dropping = 1; ovf = 1;
                  if (m_drop < 65535) m_drop++;
               end else begin
                  m_len = int'(in_len);
                  m_rem = (pc >= m_len) ? 0 : m_len - pc;
                  nb.start = 1; nb.last = (m_rem == 0); nb.len = m_len;
                  nb.mask = in_mask; nb.data = in_data;
                  do_push = 1;
                  m_in_msg = (m_rem != 0);
               end
            end
         end else if (m_in_msg) begin
            if (pc > m_rem) begin
               lerr = 1; m_rem = 0;
            end else begin
               m_rem -= pc;
            end
            nb.start = 0; nb.last = (m_rem == 0); nb.len = m_len;
            nb.mask = in_mask; nb.data = in_data;
            do_push = (occ < DEPTH);
            m_in_msg = (m_rem != 0);
         end else if (!m_dropping) begin
            lerr = 1;
         end
      end
      if (in_rdy && occ > 0) void'(q.pop_front());
      if (do_push) q.push_back(nb);
      exp_lerr = lerr;
      exp_ovf  = ovf;
   endtask

   task automatic drive(input logic v, input logic st, input logic [15:0] len,
                        input logic [7:0] mask, input logic [63:0] data);
      in_v = v; in_start = st; in_len = len; in_mask = mask; in_data = data;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 16'd0, 8'd0, 64'd0);
   endtask

   // Model is advanced with the inputs of this cycle, then the DUT clocks.
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // ------------------------------------------------------------------
   task automatic test_reset();
      nreset = 1'b0; in_rdy = 1'b0; idle();
      model_reset();
      @(negedge clk); @(negedge clk);
      checks++; if (out_v_o !== 1'b0) begin errors++; $display("FAIL reset_out_v: got %b want 0", out_v_o); end
      checks++; if (len_err_o !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b want 0", len_err_o); end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
      checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %h want 0000", drop_cnt_o); end
      nreset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [63:0] d0, d1, d2;
      d0 = rnd64(); d1 = rnd64(); d2 = rnd64();
      in_rdy = 1'b1;
      drive(1'b1, 1'b1, 16'd20, 8'hFF, d0);
      checks++; if (out_v_o !== 1'b0) begin errors++; $display("FAIL basic_pre_v: got %b want 0", out_v_o); end
      tick();
      checks++; if (out_v_o !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b want 1", out_v_o); end
      checks++; if (dut_head !== {1'b1, 1'b0, 16'd20, 8'hFF, d0}) begin errors++; $display("FAIL basic_beat0: got %h want %h", dut_head, {1'b1, 1'b0, 16'd20, 8'hFF, d0}); end
      drive(1'b1, 1'b0, 16'd0, 8'hFF, d1);
      tick();
      checks++; if (dut_head !== {1'b0, 1'b0, 16'd20, 8'hFF, d1}) begin errors++; $display("FAIL basic_beat1: got %h want %h", dut_head, {1'b0, 1'b0, 16'd20, 8'hFF, d1}); end
      drive(1'b1, 1'b0, 16'd0, 8'h0F, d2);
      tick();
      checks++; if (dut_head !== {1'b0, 1'b1, 16'd20, 8'h0F, d2}) begin errors++; $display("FAIL basic_beat2: got %h want %h", dut_head, {1'b0, 1'b1, 16'd20, 8'h0F, d2}); end
      checks++; if (len_err_o !== 1'b0) begin errors++; $display("FAIL basic_len_err: got %b want 0", len_err_o); end
      idle();
      tick();
      checks++; if (out_v_o !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", out_v_o); end
   endtask

   task automatic test_overflow();
      int n;
      in_rdy = 1'b0;
      drive(1'b1, 1'b1, 16'd48, 8'hFF, rnd64());
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 16'd0, 8'hFF, rnd64());
         tick();
      end
      drive(1'b1, 1'b1, 16'd24, 8'hFF, rnd64());
      tick();
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", overflow_o); end
      checks++; if (drop_cnt_o !== 16'd1) begin errors++; $display("FAIL ovf_drop_cnt: got %h want 0001", drop_cnt_o); end
      drive(1'b1, 1'b0, 16'd0, 8'hFF, rnd64());
      tick();
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_single: got %b want 0", overflow_o); end
      checks++; if (len_err_o !== 1'b0) begin errors++; $display("FAIL ovf_drop_beat_err: got %b want 0", len_err_o); end
      drive(1'b1, 1'b0, 16'd0, 8'hFF, rnd64());
      tick();
      idle();
      in_rdy = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_v_o === 1'b1) begin
            n++;
            checks++; if (q.size() == 0 || dut_head !== exp_head()) begin errors++; $display("FAIL ovf_drain_beat: got %h want model head", dut_head); end
         end
         tick();
      end
      checks++; if (n !== 6) begin errors++; $display("FAIL ovf_occupancy: got %0d want 6", n); end
   endtask

   task automatic test_len_err();
      in_rdy = 1'b0;
      drive(1'b1, 1'b1, 16'd16, 8'hFF, rnd64());
      tick();
      drive(1'b1, 1'b1, 16'd8, 8'hFF, rnd64());
      tick();
      checks++; if (len_err_o !== 1'b1) begin errors++; $display("FAIL trunc_len_err: got %b want 1", len_err_o); end
      idle();
      tick();
      checks++; if (len_err_o !== 1'b0) begin errors++; $display("FAIL trunc_len_err_single: got %b want 0", len_err_o); end
      in_rdy = 1'b1;
      checks++; if (dut_head !== {1'b1, 1'b0, 16'd16, 8'hFF, q[0].data}) begin errors++; $display("FAIL trunc_first: got %h want start=1 last=0 len=16", dut_head); end
      tick();
      checks++; if (dut_head !== {1'b1, 1'b1, 16'd8, 8'hFF, q[0].data}) begin errors++; $display("FAIL trunc_second: got %h want start=1 last=1 len=8", dut_head); end
      tick();
      checks++; if (out_v_o !== 1'b0) begin errors++; $display("FAIL trunc_empty: got %b want 0", out_v_o); end
   endtask

   task automatic test_reset_mid();
      in_rdy = 1'b0;
      drive(1'b1, 1'b1, 16'd40, 8'hFF, rnd64());
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 16'd0, 8'hFF, rnd64());
         tick();
      end
      idle();
      checks++; if (out_v_o !== 1'b1) begin errors++; $display("FAIL rstmid_queued: got %b want 1", out_v_o); end
      #2 nreset = 1'b0;
      #1;
      checks++; if (out_v_o !== 1'b0) begin errors++; $display("FAIL rstmid_async_v: got %b want 0", out_v_o); end
      checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL rstmid_drop_cnt: got %h want 0000", drop_cnt_o); end
      model_reset();
      @(posedge clk); @(negedge clk);
      nreset = 1'b1;
      drive(1'b1, 1'b0, 16'd0, 8'hFF, rnd64());
      tick();
      checks++; if (len_err_o !== 1'b1) begin errors++; $display("FAIL rstmid_stray_err: got %b want 1", len_err_o); end
      checks++; if (out_v_o !== 1'b0) begin errors++; $display("FAIL rstmid_stray_v: got %b want 0", out_v_o); end
      idle();
      tick();
   endtask

   task automatic test_random();
      int          gen_rem, n, len;
      bit          prev_v, prev_rdy;
      logic [89:0] prev_head;
      gen_rem = 0; prev_v = 0; prev_rdy = 1;
      prev_head = '0;
      for (int i = 0; i < 2000; i++) begin
         in_rdy = ($urandom_range(0, 99) < (((i % 200) < 100) ? 25 : 70));
         if ($urandom_range(0, 3) == 0) begin
            idle();
         end else if (gen_rem == 0 || $urandom_range(0, 19) == 0) begin
            if (gen_rem == 0 && $urandom_range(0, 14) == 0) begin
               drive(1'b1, 1'b0, 16'd0, 8'hFF, rnd64());
            end else begin
               len = ($urandom_range(0, 49) == 0) ? 0 : int'($urandom_range(1, 40));
               n = (len > 8) ? 8 : len;
               drive(1'b1, 1'b1, 16'(len), (len == 0) ? 8'hFF : thermo(n), rnd64());
               gen_rem = len - n;
            end
         end else begin
            n = (gen_rem > 8) ? 8 : gen_rem;
            drive(1'b1, 1'b0, 16'd0, thermo(n), rnd64());
            gen_rem -= n;
         end
         checks++; if (out_v_o !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid: got %b want %b", out_v_o, (q.size() != 0)); end
         if (q.size() != 0) begin
            checks++; if (dut_head !== exp_head()) begin errors++; $display("FAIL rnd_head: got %h want %h", dut_head, exp_head()); end
         end
         if (prev_v && !prev_rdy && out_v_o) begin
            checks++; if (dut_head !== prev_head) begin errors++; $display("FAIL rnd_stall_stable: got %h want %h", dut_head, prev_head); end
         end
         checks++; if (len_err_o !== exp_lerr) begin errors++; $display("FAIL rnd_len_err: got %b want %b", len_err_o, exp_lerr); end
         checks++; if (overflow_o !== exp_ovf) begin errors++; $display("FAIL rnd_overflow: got %b want %b", overflow_o, exp_ovf); end
         checks++; if (drop_cnt_o !== 16'(m_drop)) begin errors++; $display("FAIL rnd_drop_cnt: got %h want %h", drop_cnt_o, 16'(m_drop)); end
         prev_v = out_v_o; prev_rdy = in_rdy; prev_head = dut_head;
         tick();
      end
      idle();
   endtask

   task automatic test_saturate();
      int n;
      nreset = 1'b0; in_rdy = 1'b0; idle();
      model_reset();
      @(negedge clk);
      nreset = 1'b1;
      drive(1'b1, 1'b1, 16'd64, 8'hFF, rnd64());
      tick();
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 1'b0, 16'd0, 8'hFF, rnd64());
         tick();
      end
      for (int i = 0; i < 65536; i++) begin
         drive(1'b1, 1'b1, 16'd8, 8'hFF, 64'(i));
         tick();
      end
      checks++; if (drop_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_65536: got %h want ffff", drop_cnt_o); end
      drive(1'b1, 1'b1, 16'd8, 8'hFF, rnd64());
      tick();
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL sat_ovf_pulse: got %b want 1", overflow_o); end
      checks++; if (drop_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", drop_cnt_o); end
      idle();
      in_rdy = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_v_o === 1'b1) begin
            n++;
            checks++; if (q.size() == 0 || dut_head !== exp_head()) begin errors++; $display("FAIL sat_drain_beat: got %h want model head", dut_head); end
         end
         tick();
      end
      checks++; if (n !== 8) begin errors++; $display("FAIL sat_kept_beats: got %0d want 8", n); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_len_err();
      test_reset_mid();
      test_random();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mold_msg_buf
`default_nettype wire

// File: doc/mold_msg_buf.md
MOLD_MSG_BUF -- requirements
Module: mold_msg_buf

Interface
REQ-001 SHALL have parameter AXI_DATA_W, default 64, message data beat width in bits.
REQ-002 SHALL have parameter AXI_KEEP_W, default 8, byte-mask width (AXI_DATA_W/8).
REQ-003 SHALL have parameter ML_W, default 16, Mold message length field width.
REQ-004 SHALL have parameter DEPTH, default 8, FIFO entries in beats; power of 2 and at least 2.
REQ-005 SHALL have port clk, input, 1, single clock for all state.
REQ-006 SHALL have port nreset, input, 1, reset, asynchronous assert, active-low.
REQ-007 SHALL have ports mold_msg_v_i / mold_msg_start_i, input, 1 each, beat valid / first beat of message. There is no upstream ready.
REQ-008 SHALL have ports mold_msg_len_i (ML_W), mold_msg_mask_i (AXI_KEEP_W) and mold_msg_data_i (AXI_DATA_W), all inputs: length in bytes (meaningful on start), thermometer byte mask, and payload.
REQ-009 SHALL have port out_ready_i, input, 1, consumer ready.
REQ-010 SHALL have ports out_v_o, out_start_o and out_last_o, outputs, 1 each: beat valid, first beat, final beat.
REQ-011 SHALL have ports out_len_o (ML_W), out_mask_o (AXI_KEEP_W) and out_data_o (AXI_DATA_W), all outputs: beat fields.
REQ-012 SHALL have port drop_cnt_o, output, 16, saturating count of dropped messages.
REQ-013 SHALL have ports len_err_o and overflow_o, outputs, 1 each, single-cycle error pulses.

Function
REQ-014 SHALL run the admission FSM with states IDLE, PASS and DROP.
REQ-015 SHALL, on a start beat, compute need = ceil(len/(AXI_DATA_W/8)) and free = DEPTH - registered occupancy; a pop in the same cycle is not credited.
REQ-016 SHALL, on a start beat with need <= free and len != 0: push the beat, load rem = len - popcount(mask), and go to PASS (or stay IDLE if rem == 0).
REQ-017 SHALL, on a start beat with need > free: discard the beat, go to DROP, pulse overflow_o, and increment drop_cnt_o (saturate at 0xFFFF).
REQ-018 SHALL, on a start beat with len == 0: discard the beat, pulse len_err_o, and stay in or return to IDLE.
REQ-019 SHALL, in PASS on a non-start beat: push the beat, set rem -= popcount(mask), and go to IDLE when rem reaches 0.
REQ-020 SHALL tag a beat last=1 when, after it, rem == 0; out_len_o carries the message length on every beat.
REQ-021 SHALL, when popcount(mask) > rem on a non-start beat in PASS: pulse len_err_o, push the beat with last=1, and go to IDLE.
REQ-022 SHALL, on a start beat while in PASS: pulse len_err_o, then evaluate the beat as a new start (REQ-016/017). The truncated message carries no last beat.
REQ-023 SHALL discard, in DROP, all non-start beats; a start beat is evaluated per REQ-016..018.
REQ-024 SHALL discard a non-start beat in IDLE and pulse len_err_o.
REQ-025 SHALL make admission guarantee no push ever occurs while full; full = (occupancy == DEPTH).
REQ-026 SHALL pop when out_v_o & out_ready_i; out_v_o = occupancy != 0; output fields come directly from the head entry (first-word fall-through).
REQ-027 SHALL give push-to-out_v_o latency of 1 cycle when empty; simultaneous push and pop leaves occupancy unchanged.
REQ-028 SHALL hold out_* stable while out_v_o & ~out_ready_i.
REQ-029 SHALL use pointers of log2(DEPTH) bits with natural wrap and an occupancy counter of log2(DEPTH)+1 bits.

Reset
REQ-030 SHALL, while nreset is low: FSM=IDLE, pointers=0, occupancy=0, rem=0, drop_cnt_o=0, out_v_o=0, len_err_o=0, overflow_o=0.
REQ-031 SHALL leave FIFO storage unreset; out data/mask/len/start/last are don't-care while out_v_o=0.
REQ-032 SHALL, on reset mid-message, drop the partial message with no count increment; the first post-reset beat must be a start beat (else REQ-024).

Structure
REQ-033 SHALL place the FSM state enum, entry struct {start, last, len, mask, data}, and default widths in shared package mold_pkg.
REQ-034 SHALL implement storage as sub-module mold_fifo (DEPTH entries, push/pop, occupancy out); the popcount reuses cnt_ones_thermo.

Verification
REQ-035 SHALL cover: start len=20 with beats of mask 0xFF, 0xFF, 0x0F and ready=1 -> 3 beats out, start on beat 0, last on beat 2, out_len=20, first out_v 1 cycle after push.
REQ-036 SHALL cover: ready=0, DEPTH=8, message len=48 (6 beats) then start len=24 (3 beats) -> second dropped, overflow_o one pulse, drop_cnt=1, occupancy stays 6.
REQ-037 SHALL cover: start len=16 mask 0xFF, then start len=8 -> len_err_o pulse, second message accepted, first has no last.
REQ-038 SHALL cover: 65536 overflowing messages followed by one more -> drop_cnt_o holds 0xFFFF.
REQ-039 SHALL cover: nreset asserted mid-message with 3 beats queued -> out_v_o=0 immediately (async), drop_cnt=0; a non-start beat after release -> len_err_o pulse.
REQ-040 SHALL cover: full FIFO with out_ready_i toggling randomly -> in-order delivery, fields stable under stall, no loss of admitted beats.
